// File: rtl/fpga_exec_pkg.sv
// Shared types for the Zero-subset execution core.
// - op_e     : instruction opcodes (11..15 are illegal and fall to default)
// - state_e  : core FSM states
// - instr_t  : instruction layout at the default widths (op, f1, f2, t; MSB first)
// - *_lsb()  : field offsets for any (element width, pointer width) pair
package fpga_exec_pkg;

  localparam int DEF_MEW = 12;
  localparam int DEF_PW  = 6;
  localparam int OP_W    = 4;

  typedef enum logic [3:0] {
    OP_LABEL = 4'd0,
    OP_MOV   = 4'd1,
    OP_MOVL  = 4'd2,
    OP_JEQ   = 4'd3,
    OP_JNE   = 4'd4,
    OP_JLT   = 4'd5,
    OP_JGE   = 4'd6,
    OP_JMP   = 4'd7,
    OP_OUT   = 4'd8,
    OP_OUTL  = 4'd9,
    OP_HALT  = 4'd10
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OSTALL, S_DONE} state_e;

  typedef struct packed {
    op_e                op;
    logic [DEF_MEW-1:0] f1;
    logic [DEF_MEW-1:0] f2;
    logic [DEF_PW-1:0]  t;
  } instr_t;

  function automatic int f2_lsb(input int pw);
    return pw;
  endfunction

  function automatic int f1_lsb(input int mew, input int pw);
    return pw + mew;
  endfunction

  function automatic int op_lsb(input int mew, input int pw);
    return pw + 2 * mew;
  endfunction

endpackage

// File: rtl/fpga_exec_if.sv
// Harness-side bundle of the execution core: run/load controls, the output
// valid/ready stream, and the finished/success/error/ip status.
// master = test harness, slave = fpga_exec_core.
interface fpga_exec_if #(
  parameter int MEW = 12,
  parameter int PW  = 6,
  parameter int EW  = 4,
  parameter int IW  = 4 + 2 * MEW + PW
);
  logic          run;
  logic          load_valid;
  logic          load_sel;
  logic [PW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [EW-1:0] expect_count;
  logic          out_valid;
  logic          out_ready;
  logic [MEW-1:0] out_data;
  logic          finished;
  logic          success;
  logic          error;
  logic [PW-1:0] ip_dbg;

  modport master (
    output run, load_valid, load_sel, load_addr, load_data, expect_count, out_ready,
    input  out_valid, out_data, finished, success, error, ip_dbg
  );

  modport slave (
    input  run, load_valid, load_sel, load_addr, load_data, expect_count, out_ready,
    output out_valid, out_data, finished, success, error, ip_dbg
  );
endinterface

// File: rtl/fpga_exec_checker.sv
// Output checker: holds the expected-output vector, counts accepted words and
// keeps a sticky mismatch flag. pass reflects the state *including* a handshake
// happening this cycle, so the core can latch success on the same edge.
// Ports: clock/reset, start (clear + latch expect_count), load_en/addr/data
// (expected memory write), hs/out_data (accepted word), pass.
module fpga_exec_checker #(
  parameter int MEW     = 12,
  parameter int NExpect = 8,
  parameter int EW      = 4,
  parameter int XW      = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [EW-1:0]  expect_count,
  input  logic           load_en,
  input  logic [XW-1:0]  load_addr,
  input  logic [MEW-1:0] load_data,
  input  logic           hs,
  input  logic [MEW-1:0] out_data,
  output logic           pass
);
  logic [MEW-1:0] exp_mem [NExpect];
  logic [EW-1:0]  exp_cnt, cnt, cnt_n;
  logic           mismatch, bad;

  always_ff @(posedge clock)
    if (load_en) exp_mem[load_addr] <= load_data;

  // Extra words (beyond expect_count or the memory depth) count as mismatches.
  assign bad   = hs && ((cnt >= exp_cnt) || (cnt >= EW'(NExpect)) ||
                        (out_data != exp_mem[cnt[XW-1:0]]));
  assign cnt_n = cnt + EW'(hs);
  assign pass  = !(mismatch || bad) && (cnt_n == exp_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      exp_cnt  <= '0;
      mismatch <= 1'b0;
    end else if (start) begin
      cnt      <= '0;
      exp_cnt  <= expect_count;
      mismatch <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      mismatch <= mismatch | bad;
    end
  end
endmodule

// File: rtl/fpga_exec_core.sv
// Zero-subset program runner: one instruction per cycle from a loadable code
// memory, 8-entry local memory, output words streamed over valid/ready and
// checked against a loaded expected vector.
// Ports: clock, reset (async, active high), bus (fpga_exec_if.slave).
module fpga_exec_core
  import fpga_exec_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal             = 8,
  parameter int NCode              = 64,
  parameter int NExpect            = 8,
  parameter int MaxSteps           = 1024
) (
  input logic        clock,
  input logic        reset,
  fpga_exec_if.slave bus
);
  localparam int MEW    = MemoryElementWidth;
  localparam int LW     = $clog2(NLocal);
  localparam int PW     = $clog2(NCode);
  localparam int EW     = $clog2(NExpect + 1);
  localparam int XW     = $clog2(NExpect);
  localparam int IW     = 4 + 2 * MEW + PW;
  localparam int SW     = $clog2(MaxSteps + 1);
  localparam int F2_LSB = f2_lsb(PW);
  localparam int F1_LSB = f1_lsb(MEW, PW);
  localparam int OP_LSB = op_lsb(MEW, PW);
  localparam logic [PW-1:0] LAST_IP = PW'(NCode - 1);

  logic [IW-1:0]  code_mem [NCode];
  logic [MEW-1:0] lmem [NLocal];

  state_e         state, state_n;
  logic [PW-1:0]  ip, ip_n;
  logic [SW-1:0]  steps, steps_n;
  logic           out_valid, out_valid_n;
  logic [MEW-1:0] out_data, out_data_n;
  logic           finished, finished_n, success, success_n, error, error_n;

  logic [IW-1:0]  ins;
  op_e            op;
  logic [MEW-1:0] f1, f2, a, b;
  logic [PW-1:0]  tgt;
  logic           f1_ok, f2_ok, taken, busy, start, hs, seq, fault, stop, pass;
  logic           lwe;
  logic [LW-1:0]  lwa;
  logic [MEW-1:0] lwd;

  assign ins   = code_mem[ip];
  assign op    = op_e'(ins[OP_LSB +: OP_W]);
  assign f1    = ins[F1_LSB +: MEW];
  assign f2    = ins[F2_LSB +: MEW];
  assign tgt   = ins[PW-1:0];
  assign f1_ok = (f1 >> LW) == '0;
  assign f2_ok = (f2 >> LW) == '0;
  assign a     = lmem[f1[LW-1:0]];
  assign b     = lmem[f2[LW-1:0]];
  assign busy  = (state == S_RUN) || (state == S_OSTALL);
  assign hs    = out_valid && bus.out_ready;

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JEQ:  taken = (a == b);
      OP_JNE:  taken = (a != b);
      OP_JLT:  taken = (a <  b);
      OP_JGE:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state;
    ip_n        = ip;
    steps_n     = steps;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    finished_n  = finished;
    success_n   = success;
    error_n     = error;
    start       = 1'b0;
    seq         = 1'b0;
    fault       = 1'b0;
    stop        = 1'b0;
    lwe         = 1'b0;
    lwa         = f1[LW-1:0];
    lwd         = f2;
    case (state)
      S_IDLE, S_DONE:
        if (bus.run) begin
          start      = 1'b1;
          state_n    = S_RUN;
          ip_n       = '0;
          steps_n    = '0;
          finished_n = 1'b0;
          success_n  = 1'b0;
          error_n    = 1'b0;
        end
      S_RUN:
        // Budget is checked before fetching, so exactly MaxSteps instructions run.
        if (steps == SW'(MaxSteps)) fault = 1'b1;
        else begin
          steps_n = steps + SW'(1);
          case (op)
            OP_LABEL: seq = 1'b1;
            OP_MOV:   if (f1_ok) begin lwe = 1'b1; seq = 1'b1; end else fault = 1'b1;
            OP_MOVL:  if (f1_ok && f2_ok) begin lwe = 1'b1; lwd = b; seq = 1'b1; end
                      else fault = 1'b1;
            OP_JEQ, OP_JNE, OP_JLT, OP_JGE:
              if (!(f1_ok && f2_ok)) fault = 1'b1;
              else if (taken) ip_n = tgt;
              else seq = 1'b1;
            OP_JMP:   ip_n = tgt;
            OP_OUT:   begin out_valid_n = 1'b1; out_data_n = f2; state_n = S_OSTALL; end
            OP_OUTL:  if (f2_ok) begin out_valid_n = 1'b1; out_data_n = b; state_n = S_OSTALL; end
                      else fault = 1'b1;
            OP_HALT:  stop = 1'b1;
            default:  fault = 1'b1;
          endcase
          // A faulting instruction is not counted as executed.
          if (fault) steps_n = steps;
        end
      S_OSTALL:
        if (hs) begin
          out_valid_n = 1'b0;
          seq         = 1'b1;
          state_n     = S_RUN;
        end
      default: state_n = S_IDLE;
    endcase
    // Falling off the last code word ends the program like a halt.
    if (seq) begin
      if (ip == LAST_IP) stop = 1'b1;
      else ip_n = ip + PW'(1);
    end
    if (stop) begin
      state_n    = S_DONE;
      finished_n = 1'b1;
      success_n  = pass;
    end
    if (fault) begin
      state_n    = S_DONE;
      finished_n = 1'b1;
      error_n    = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ip        <= '0;
      steps     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      finished  <= 1'b0;
      success   <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      ip        <= ip_n;
      steps     <= steps_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      finished  <= finished_n;
      success   <= success_n;
      error     <= error_n;
    end
  end

  always_ff @(posedge clock)
    if (bus.load_valid && !bus.load_sel && !busy) code_mem[bus.load_addr] <= bus.load_data;

  always_ff @(posedge clock) begin
    if (start) for (int i = 0; i < NLocal; i++) lmem[i] <= '0;
    else if (lwe) lmem[lwa] <= lwd;
  end

  fpga_exec_checker #(.MEW(MEW), .NExpect(NExpect), .EW(EW), .XW(XW)) u_chk (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .expect_count (bus.expect_count),
    .load_en      (bus.load_valid && bus.load_sel && !busy),
    .load_addr    (bus.load_addr[XW-1:0]),
    .load_data    (bus.load_data[MEW-1:0]),
    .hs           (hs),
    .out_data     (out_data),
    .pass         (pass)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.finished  = finished;
  assign bus.success   = success;
  assign bus.error     = error;
  assign bus.ip_dbg    = ip;
endmodule

// File: doc/fpga_exec_core.md
Name: fpga_exec_core

Overview:
- Clocked, parametrised successor to the per-test generated program runners.
- Executes a small Zero instruction subset (label, mov, compare-and-jump, jmp, out, halt) from a loadable code memory, one instruction per cycle.
- Streams output words over a valid/ready channel and checks them against a loaded expected vector.
- Reports finished/success to the FPGA test harness.

Parameters:
- MemoryElementWidth, 12: data width of local, output and expected words.
- NLocal, 8: local memory words; LW = $clog2(NLocal).
- NCode, 64: code memory depth; PW = $clog2(NCode).
- NExpect, 8: expected-output vector depth; EW = $clog2(NExpect+1).
- MaxSteps, 1024: executed-instruction limit before timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start pulse; sampled only in IDLE/DONE.
- load_valid  in  1  write strobe for code or expected memory; honoured only when not RUNNING.
- load_sel  in  1  0 = code memory, 1 = expected memory.
- load_addr  in  PW  write address; expected memory uses the low bits.
- load_data  in  IW  write data; IW = 4+2*MemoryElementWidth+PW; expected memory uses the low MemoryElementWidth bits.
- expect_count  in  EW  number of expected outputs; latched on run.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  MemoryElementWidth  output word.
- finished  out  1  program ended (halt, run-off, error or timeout).
- success  out  1  valid only with finished.
- error  out  1  illegal opcode, out-of-range local index, or timeout.
- ip_dbg  out  PW  current instruction pointer.

Behaviour:
- Instruction fields, MSB first: op[4], f1[MemoryElementWidth], f2[MemoryElementWidth], t[PW].
- Local indices use f1/f2 low LW bits; upper bits must be zero, otherwise error.
- Opcodes:
  - 0 label: no operation.
  - 1 mov: local[f1] = f2 (immediate).
  - 2 movl: local[f1] = local[f2].
  - 3 jEq, 4 jNe, 5 jLt, 6 jGe: compare local[f1] with local[f2], unsigned; if true ip = t, else ip+1.
  - 7 jmp: ip = t.
  - 8 out: emit f2.
  - 9 outl: emit local[f2].
  - 10 halt.
  - 11-15: illegal, sets error.
- States: IDLE, RUN, OSTALL, DONE.
- Reset: state IDLE; ip, steps, out count = 0; out_valid, finished, success, error = 0. Code and expected memories are not cleared.
- IDLE/DONE + run: clear all local memory, ip, steps and out count; latch expect_count; clear finished/success/error; go to RUN next cycle.
- RUN: one instruction per cycle, code memory read combinationally at ip. steps increments per executed instruction.
- out/outl in RUN:
  - Drive out_valid = 1 with out_data registered.
  - Go to OSTALL; ip advances only on the handshake (out_valid && out_ready).
  - out_data holds stable while stalled.
  - On handshake: compare against expected[outCount]. A mismatch, or outCount >= expect_count, sets a sticky mismatch flag. outCount increments.
- Termination, all → DONE with finished = 1:
  - halt.
  - ip reaching NCode-1 and stepping past it (run-off, treated as halt).
  - Illegal op or out-of-range index (error = 1).
  - steps == MaxSteps (error = 1).
- success = halt-or-run-off && !error && !mismatch && outCount == expect_count. Computed on DONE entry, held until next run.
- run asserted while in RUN/OSTALL: ignored. load_valid while RUN/OSTALL: ignored.
- Jump target equal to ip (self-loop) is legal; it ends only by timeout.
- Asynchronous reset mid-run: immediate return to IDLE; an out_valid in flight is dropped.

Decomposition:
- Package fpga_exec_pkg: opcode enum, state enum, field-slice localparams, instruction struct.
- Sub-module fpga_exec_checker: expected memory, outCount, mismatch flag, success term.
- Core: FSM, code and local memory.

Test Plan:
- Program: mov L0=1; mov L1=2; jEq L0,L1→7; out 111; jEq L0,L0→7; out 999; halt; out 333; halt. Expected {111,333}, count 2, out_ready=1. → Output 111, 333; finished=1, success=1, error=0; 999 never emitted.
- Same program with out_ready low 5 cycles at each word. → out_data held stable; ip_dbg frozen while stalled; same result.
- Expected {111,334}. → finished=1, success=0, error=0.
- Code word with op=12 at ip 2. → finished=1, error=1, success=0, exactly 2 instructions executed.
- jmp to self with MaxSteps=16. → finished after 16 steps, error=1.
- Assert reset during OSTALL, then run again. → out_valid drops immediately; rerun passes with code memory intact.
